// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 decipher controller: FSM encoding,
// round count, round-timeout length and key index width.
package aes_pkg;

    localparam int NUM_ROUNDS    = 10;
    localparam int ROUND_TIMEOUT = 32;
    localparam int KEY_IDX_W     = 4;
    localparam int TIMER_W       = $clog2(ROUND_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        KEYW,
        WHITEN,
        ISSUE,
        WAIT,
        DONE,
        ERROR
    } state_t;

endpackage

// File: rtl/aes_round_timer.sv
// Counts consecutive WAIT cycles without a round result; expired marks the
// last cycle the controller may still wait before declaring a timeout.
module aes_round_timer
    import aes_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == TIMER_W'(ROUND_TIMEOUT - 1));

endmodule

// File: rtl/aes_decipher_ctrl.sv
// AES-128 decipher sequencer: whitens the ciphertext with key 10, then drives
// an external inverse-round block through keys 9..0 and presents the plaintext.
module aes_decipher_ctrl
    import aes_pkg::*;
#(
    parameter int DATA_W = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [DATA_W-1:0]    block_in,
    output logic                 ready,
    output logic                 out_valid,
    output logic [DATA_W-1:0]    block_out,
    output logic                 error,
    output logic [KEY_IDX_W-1:0] key_idx,
    input  logic [DATA_W-1:0]    round_key,
    output logic                 rnd_start,
    output logic [DATA_W-1:0]    rnd_data,
    output logic                 last_round,
    input  logic                 rnd_done,
    input  logic [DATA_W-1:0]    rnd_result
);

    state_t               state;
    logic [KEY_IDX_W-1:0] round;
    logic                 timer_clear;
    logic                 timer_en;
    logic                 timer_expired;

    assign timer_clear = (state == ISSUE);
    assign timer_en    = (state == WAIT) && !rnd_done;
    assign rnd_data    = block_out;

    aes_round_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (timer_expired)
    );

    // Outputs are registered: each is set on the edge that enters the state it belongs to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ready      <= 1'b1;
            out_valid  <= 1'b0;
            error      <= 1'b0;
            rnd_start  <= 1'b0;
            last_round <= 1'b0;
            key_idx    <= '0;
            round      <= '0;
            block_out  <= '0;
        end else begin
            out_valid <= 1'b0;
            rnd_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        block_out <= block_in;
                        key_idx   <= KEY_IDX_W'(NUM_ROUNDS);
                        round     <= KEY_IDX_W'(NUM_ROUNDS);
                        ready     <= 1'b0;
                        state     <= KEYW;
                    end
                end
                KEYW: begin
                    state <= WHITEN;
                end
                WHITEN: begin
                    block_out  <= block_out ^ round_key;
                    key_idx    <= KEY_IDX_W'(NUM_ROUNDS - 1);
                    round      <= KEY_IDX_W'(NUM_ROUNDS - 1);
                    rnd_start  <= 1'b1;
                    last_round <= 1'b0;
                    state      <= ISSUE;
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    // A result arriving on the expiry cycle still wins over the timeout.
                    if (rnd_done) begin
                        block_out <= rnd_result;
                        if (round == '0) begin
                            last_round <= 1'b0;
                            out_valid  <= 1'b1;
                            state      <= DONE;
                        end else begin
                            round      <= round - 1'b1;
                            key_idx    <= key_idx - 1'b1;
                            rnd_start  <= 1'b1;
                            last_round <= (round == KEY_IDX_W'(1));
                            state      <= ISSUE;
                        end
                    end else if (timer_expired) begin
                        last_round <= 1'b0;
                        error      <= 1'b1;
                        state      <= ERROR;
                    end
                end
                DONE: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
                ERROR: begin
                    state <= ERROR;
                end
                default: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_decipher_ctrl.sv
// Bench for aes_decipher_ctrl: key store and latency-programmable inverse-round
// model around the DUT, expected plaintext from a forward AES-128 reference.
module tb_aes_decipher_ctrl;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [127:0] block_in = '0;
    logic         ready;
    logic         out_valid;
    logic [127:0] block_out;
    logic         error;
    logic [3:0]   key_idx;
    logic [127:0] round_key = '0;
    logic         rnd_start;
    logic [127:0] rnd_data;
    logic         last_round;
    logic         rnd_done = 1'b0;
    logic [127:0] rnd_result = '0;

    aes_decipher_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .block_in   (block_in),
        .ready      (ready),
        .out_valid  (out_valid),
        .block_out  (block_out),
        .error      (error),
        .key_idx    (key_idx),
        .round_key  (round_key),
        .rnd_start  (rnd_start),
        .rnd_data   (rnd_data),
        .last_round (last_round),
        .rnd_done   (rnd_done),
        .rnd_result (rnd_result)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [7:0]   sbox  [256];
    logic [7:0]   isbox [256];
    logic [127:0] rk    [16];

    int           latency = 4;
    int           silent_idx = -1;
    bit           busy = 1'b0;
    int           cnt = 0;
    logic [127:0] pend = '0;
    int           ov_count = 0;
    int           lr_bad = 0;
    int           kq[$];
    bit           lq[$];

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

    // ---------------- AES reference arithmetic ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] gb(input logic [127:0] v, input int i);
        return v[127-8*i -: 8];
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] v, input bit inv);
        logic [127:0] o = '0;
        for (int i = 0; i < 16; i++)
            o[127-8*i -: 8] = inv ? isbox[gb(v, i)] : sbox[gb(v, i)];
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] v, input bit inv);
        logic [127:0] o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = gb(v, r + 4*(inv ? (c+4-r)%4 : (c+r)%4));
        return o;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] v, input bit inv);
        logic [127:0] o = '0;
        logic [7:0]   cf[4];
        logic [7:0]   b;
        if (inv) cf = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     cf = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                b = 8'h00;
                for (int j = 0; j < 4; j++) b ^= gmul(gb(v, 4*c+j), cf[(j-r+4)%4]);
                o[127-8*(4*c+r) -: 8] = b;
            end
        return o;
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] p);
        logic [127:0] s = p ^ rk[0];
        for (int r = 1; r <= 10; r++) begin
            s = shift_rows(sub_bytes(s, 1'b0), 1'b0);
            if (r != 10) s = mix_cols(s, 1'b0);
            s ^= rk[r];
        end
        return s;
    endfunction

    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [127:0] o = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ k;
        if (!last) o = mix_cols(o, 1'b1);
        return o;
    endfunction

    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] b;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox[x]  = b;
            isbox[b] = 8'(x);
        end
    endtask

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w[44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int k = 0; k < 16; k++)
            rk[k] = (k <= 10) ? {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]} : '0;
    endtask

    // ---------------- key store, round block and monitors ----------------
    always @(posedge clk) begin
        rnd_done  <= 1'b0;
        round_key <= rk[key_idx];
        if (reset) begin
            busy <= 1'b0;
        end else begin
            if (out_valid) ov_count <= ov_count + 1;
            if (last_round && key_idx != 4'd0) lr_bad <= lr_bad + 1;
            if (busy) begin
                if (cnt <= 1) begin
                    rnd_done   <= 1'b1;
                    rnd_result <= pend;
                    busy       <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end
            if (rnd_start) begin
                kq.push_back(int'(key_idx));
                lq.push_back(last_round);
                if (int'(key_idx) != silent_idx) begin
                    if (latency <= 1) begin
                        rnd_done   <= 1'b1;
                        rnd_result <= inv_round(rnd_data, rk[key_idx], last_round);
                    end else begin
                        busy <= 1'b1;
                        cnt  <= latency - 1;
                        pend <= inv_round(rnd_data, rk[key_idx], last_round);
                    end
                end
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ov(input string tag, output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 800) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ovseen"}, 128'(out_valid), 128'(1));
    endtask

    task automatic run_block(input string tag, input logic [127:0] ct, input int lat,
                             input logic [127:0] exp_pt);
        int          n;
        logic [39:0] seq;
        logic [9:0]  lf;
        latency = lat;
        kq.delete();
        lq.delete();
        @(negedge clk);
        chk({tag, "_ready"}, 128'(ready), 128'(1));
        block_in = ct;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_key10"}, 128'(key_idx), 128'(10));
        chk({tag, "_busy"}, 128'(ready), 128'(0));
        wait_ov(tag, n);
        chk({tag, "_cycle"}, 128'(n + 1), 128'(3 + 10 * (1 + lat)));
        chk({tag, "_data"}, block_out, exp_pt);
        chk({tag, "_err"}, 128'(error), 128'(0));
        @(negedge clk);
        chk({tag, "_pulse"}, 128'(out_valid), 128'(0));
        chk({tag, "_idle"}, 128'(ready), 128'(1));
        chk({tag, "_hold"}, block_out, exp_pt);
        seq = '0;
        lf  = '0;
        foreach (kq[i]) begin
            seq = {seq[35:0], 4'(kq[i])};
            lf  = {lf[8:0], lq[i]};
        end
        chk({tag, "_nkeys"}, 128'(kq.size()), 128'(10));
        chk({tag, "_keyseq"}, 128'(seq), 128'(40'h9876543210));
        chk({tag, "_lastrnd"}, 128'(lf), 128'(10'b0000000001));
    endtask

    // ---------------- directed sequence ----------------
    logic [127:0] pt_a, pt_b, key;
    int           n, base;

    initial begin
        build_tables();
        expand_key(FIPS_KEY);

        repeat (3) @(negedge clk);
        chk("rst_ready", 128'(ready), 128'(1));
        chk("rst_ovalid", 128'(out_valid), 128'(0));
        chk("rst_error", 128'(error), 128'(0));
        chk("rst_rnd_start", 128'(rnd_start), 128'(0));
        chk("rst_last_round", 128'(last_round), 128'(0));
        chk("rst_key_idx", 128'(key_idx), 128'(0));
        chk("rst_block_out", block_out, 128'(0));
        reset = 1'b0;

        run_block("fips_l4", FIPS_CT, 4, FIPS_PT);
        run_block("fips_l1", FIPS_CT, 1, FIPS_PT);
        run_block("fips_l31", FIPS_CT, 31, FIPS_PT);
        run_block("fips_l32", FIPS_CT, 32, FIPS_PT);

        // reset in the WAIT of the third round (key 7)
        latency = 4;
        @(negedge clk);
        block_in = FIPS_CT;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        chk("mid_key7", 128'(key_idx), 128'(7));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_ready", 128'(ready), 128'(1));
        chk("mid_rnd_start", 128'(rnd_start), 128'(0));
        chk("mid_ovalid", 128'(out_valid), 128'(0));
        chk("mid_key_idx", 128'(key_idx), 128'(0));
        chk("mid_last_round", 128'(last_round), 128'(0));
        base = ov_count;
        repeat (40) @(negedge clk);
        chk("mid_no_ov", 128'(ov_count - base), 128'(0));
        run_block("after_mid", FIPS_CT, 4, FIPS_PT);

        // round block silent on key 5: timeout after 32 WAIT cycles
        silent_idx = 5;
        latency    = 3;
        @(negedge clk);
        block_in = FIPS_CT;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        chk("to_pre_err", 128'(error), 128'(0));
        @(negedge clk);
        chk("to_err", 128'(error), 128'(1));
        chk("to_ready", 128'(ready), 128'(0));
        base     = ov_count;
        block_in = 128'hdeadbeef;
        start    = 1'b1;
        repeat (5) @(negedge clk);
        chk("to_absorb_err", 128'(error), 128'(1));
        chk("to_absorb_ready", 128'(ready), 128'(0));
        chk("to_absorb_rs", 128'(rnd_start), 128'(0));
        chk("to_absorb_ov", 128'(ov_count - base), 128'(0));
        reset = 1'b1;
        @(negedge clk);
        reset      = 1'b0;
        start      = 1'b0;
        silent_idx = -1;
        chk("to_rst_ready", 128'(ready), 128'(1));
        chk("to_rst_err", 128'(error), 128'(0));
        chk("to_rst_key", 128'(key_idx), 128'(0));
        chk("to_rst_blk", block_out, 128'(0));

        for (int i = 0; i < 3; i++) begin
            key  = {$urandom, $urandom, $urandom, $urandom};
            pt_a = {$urandom, $urandom, $urandom, $urandom};
            expand_key(key);
            run_block($sformatf("rand%0d", i), encrypt(pt_a), $urandom_range(1, 32), pt_a);
        end

        // start held through a whole block: one completion, then one re-accept
        latency = 2;
        pt_a = {$urandom, $urandom, $urandom, $urandom};
        pt_b = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        block_in = encrypt(pt_a);
        start    = 1'b1;
        @(negedge clk);
        block_in = encrypt(pt_b);
        base     = ov_count;
        wait_ov("hold1", n);
        chk("hold1_cycle", 128'(n + 1), 128'(33));
        chk("hold1_data", block_out, pt_a);
        @(negedge clk);
        chk("hold_idle", 128'(ready), 128'(1));
        @(negedge clk);
        start = 1'b0;
        chk("hold_reaccept", 128'(ready), 128'(0));
        wait_ov("hold2", n);
        chk("hold2_cycle", 128'(n + 35), 128'(67));
        chk("hold2_data", block_out, pt_b);
        chk("hold_ovcount", 128'(ov_count - base), 128'(1));

        @(negedge clk);
        chk("last_round_only_key0", 128'(lr_bad), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
